fp_add_seq: RTL and testbench

Parametrised multi-cycle floating-point adder/subtractor, the successor to the fixed 8-bit four-bit-mantissa adder used behind the board display. It handles a generic sign/exponent/fraction format with width set by parameters, and it adds a subtract mode. Alignment and normalisation run as one-bit-per-cycle shift loops under a start/busy/valid handshake. Overflow and underflow are reported as sticky-per-result flags. It sits between the switch-input registers and the display mux; the result word is held stable for display until the next start.

---
 rtl/fp_add_seq.sv | 175 +++++++++++++++++
 tb/tb_fp_add_seq.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_add_seq.sv
// Multi-cycle floating-point adder/subtractor for a generic {sign, exp, frac} format.
// Alignment and normalisation shift one bit per cycle behind a start/busy/valid handshake.
module fp_add_seq #(
  parameter int unsigned EXP_W = 3,
  parameter int unsigned MAN_W = 4,
  localparam int unsigned W = 1 + EXP_W + MAN_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         sub,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum,
  output logic         busy,
  output logic         valid,
  output logic         ovf,
  output logic         unf
);

  localparam int unsigned MantW = MAN_W + 2;
  localparam int unsigned DiffW = $clog2(MAN_W + 3);
  localparam logic [EXP_W:0]   ExpSat  = {1'b0, {EXP_W{1'b1}}};
  localparam logic [EXP_W-1:0] ExpMax  = {{(EXP_W - 1){1'b1}}, 1'b0};
  localparam logic [EXP_W:0]   ExpOne  = {{EXP_W{1'b0}}, 1'b1};
  localparam logic [DiffW-1:0] DiffMax = DiffW'(MantW);
  localparam logic [DiffW-1:0] DiffOne = DiffW'(1);

  typedef enum logic [2:0] {StIdle, StAlign, StAdd, StNorm, StDone} state_e;

  state_e           state_q, state_d;
  logic             l_sign_q, l_sign_d;
  logic             same_sign_q, same_sign_d;
  logic [MantW-1:0] mant_q, mant_d;
  logic [MantW-1:0] s_mant_q, s_mant_d;
  logic [EXP_W:0]   exp_q, exp_d;
  logic [DiffW-1:0] diff_q, diff_d;
  logic [W-1:0]     sum_q, sum_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;

  // Operand decode; a zero exponent forces the whole mantissa to zero.
  logic             a_sign, b_sign, a_ge_b;
  logic [EXP_W-1:0] a_exp, b_exp, l_exp, s_exp, exp_gap;
  logic [MAN_W-1:0] a_frac, b_frac;
  logic [MantW-1:0] a_mant, b_mant;

  assign a_sign  = a[W-1];
  assign b_sign  = b[W-1] ^ sub;
  assign a_exp   = a[W-2:MAN_W];
  assign b_exp   = b[W-2:MAN_W];
  assign a_frac  = a[MAN_W-1:0];
  assign b_frac  = b[MAN_W-1:0];
  assign a_mant  = (a_exp != '0) ? {2'b01, a_frac} : '0;
  assign b_mant  = (b_exp != '0) ? {2'b01, b_frac} : '0;
  assign a_ge_b  = {a_exp, a_mant[MAN_W-1:0]} >= {b_exp, b_mant[MAN_W-1:0]};
  assign l_exp   = a_ge_b ? a_exp : b_exp;
  assign s_exp   = a_ge_b ? b_exp : a_exp;
  assign exp_gap = l_exp - s_exp;

  logic             norm_fin, res_zero;
  logic [EXP_W:0]   res_exp;
  logic [MAN_W-1:0] res_frac;

  always_comb begin
    state_d     = state_q;
    l_sign_d    = l_sign_q;
    same_sign_d = same_sign_q;
    mant_d      = mant_q;
    s_mant_d    = s_mant_q;
    exp_d       = exp_q;
    diff_d      = diff_q;
    sum_d       = sum_q;
    ovf_d       = ovf_q;
    unf_d       = unf_q;
    norm_fin    = 1'b0;
    res_zero    = 1'b0;
    res_exp     = exp_q;
    res_frac    = mant_q[MAN_W-1:0];

    unique case (state_q)
      StIdle, StDone: begin
        if (start) begin
          l_sign_d    = a_ge_b ? a_sign : b_sign;
          same_sign_d = (a_sign == b_sign);
          mant_d      = a_ge_b ? a_mant : b_mant;
          s_mant_d    = a_ge_b ? b_mant : a_mant;
          exp_d       = {1'b0, l_exp};
          diff_d      = (32'(exp_gap) > MantW) ? DiffMax : DiffW'(exp_gap);
          ovf_d       = 1'b0;
          unf_d       = 1'b0;
          state_d     = StAlign;
        end
      end
      StAlign: begin
        if (diff_q == '0) begin
          state_d = StAdd;
        end else begin
          s_mant_d = s_mant_q >> 1;
          diff_d   = diff_q - DiffOne;
        end
      end
      StAdd: begin
        // L has the larger magnitude, so the difference never goes negative.
        mant_d  = same_sign_q ? (mant_q + s_mant_q) : (mant_q - s_mant_q);
        state_d = StNorm;
      end
      StNorm: begin
        if (mant_q[MantW-1]) begin
          norm_fin = 1'b1;
          res_exp  = exp_q + ExpOne;
          res_frac = mant_q[MAN_W:1];
        end else if (mant_q == '0) begin
          norm_fin = 1'b1;
          res_zero = 1'b1;
        end else if (mant_q[MantW-2]) begin
          norm_fin = 1'b1;
        end else if (exp_q == ExpOne) begin
          norm_fin = 1'b1;
          res_zero = 1'b1;
          unf_d    = 1'b1;
        end else begin
          mant_d = mant_q << 1;
          exp_d  = exp_q - ExpOne;
        end

        if (norm_fin) begin
          state_d = StDone;
          if (res_zero) begin
            sum_d = '0;
          end else if (res_exp >= ExpSat) begin
            sum_d = {l_sign_q, ExpMax, {MAN_W{1'b1}}};
            ovf_d = 1'b1;
          end else begin
            sum_d = {l_sign_q, res_exp[EXP_W-1:0], res_frac};
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      l_sign_q    <= 1'b0;
      same_sign_q <= 1'b0;
      mant_q      <= '0;
      s_mant_q    <= '0;
      exp_q       <= '0;
      diff_q      <= '0;
      sum_q       <= '0;
      ovf_q       <= 1'b0;
      unf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      l_sign_q    <= l_sign_d;
      same_sign_q <= same_sign_d;
      mant_q      <= mant_d;
      s_mant_q    <= s_mant_d;
      exp_q       <= exp_d;
      diff_q      <= diff_d;
      sum_q       <= sum_d;
      ovf_q       <= ovf_d;
      unf_q       <= unf_d;
    end
  end

  assign busy  = (state_q == StAlign) || (state_q == StAdd) || (state_q == StNorm);
  assign valid = (state_q == StDone);
  assign sum   = sum_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;

endmodule

// File: tb/tb_fp_add_seq.sv
// Scoreboard bench for fp_add_seq: directed cases on the default format, back-to-back
// random traffic, and a randomised sweep of an EXP_W=4 / MAN_W=7 instance.
module tb_fp_add_seq;

  localparam int W0 = 8;
  localparam int W1 = 12;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic          start0, sub0, busy0, valid0, ovf0, unf0;
  logic [W0-1:0] a0, b0, sum0;
  logic          start1, sub1, busy1, valid1, ovf1, unf1;
  logic [W1-1:0] a1, b1, sum1;

  fp_add_seq #(.EXP_W(3), .MAN_W(4)) dut0 (
    .clk(clk), .reset(reset), .start(start0), .sub(sub0), .a(a0), .b(b0),
    .sum(sum0), .busy(busy0), .valid(valid0), .ovf(ovf0), .unf(unf0)
  );

  fp_add_seq #(.EXP_W(4), .MAN_W(7)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .sub(sub1), .a(a1), .b(b1),
    .sum(sum1), .busy(busy1), .valid(valid1), .ovf(ovf1), .unf(unf1)
  );

  typedef struct {
    int sum;
    bit ovf;
    bit unf;
    int lat;
    int acc;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  int   got0  = 0;
  int   got1  = 0;
  logic v0_prev = 1'b0;
  logic v1_prev = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Reference: align with truncation, add/sub, then normalise by counting leading zeros.
  function automatic exp_t model(int ew, int mw, int av, int bv, bit s);
    exp_t r;
    int   w, sa, ea, fa, sb, eb, fb, ma, mb, ls, le, lm, ss, se, sm, d, m, e, n;
    bit   zero;
    w  = 1 + ew + mw;
    sa = (av >> (w - 1)) & 1;
    ea = (av >> mw) & ((1 << ew) - 1);
    fa = av & ((1 << mw) - 1);
    sb = ((bv >> (w - 1)) & 1) ^ int'(s);
    eb = (bv >> mw) & ((1 << ew) - 1);
    fb = bv & ((1 << mw) - 1);
    ma = (ea != 0) ? ((1 << mw) | fa) : 0;
    mb = (eb != 0) ? ((1 << mw) | fb) : 0;
    if (ea * (1 << mw) + ((ea != 0) ? fa : 0) >= eb * (1 << mw) + ((eb != 0) ? fb : 0)) begin
      ls = sa; le = ea; lm = ma; ss = sb; se = eb; sm = mb;
    end else begin
      ls = sb; le = eb; lm = mb; ss = sa; se = ea; sm = ma;
    end
    d = le - se;
    if (d > mw + 2) d = mw + 2;
    sm   = sm >> d;
    m    = (ls == ss) ? lm + sm : lm - sm;
    e    = le;
    n    = 0;
    zero = 1'b0;
    r.ovf = 1'b0;
    r.unf = 1'b0;
    if (m == 0) begin
      zero = 1'b1;
    end else if (m >= (2 << mw)) begin
      m = m >> 1;
      e = e + 1;
    end else begin
      while (m < (1 << mw)) begin
        if (e == 1) begin
          zero  = 1'b1;
          r.unf = 1'b1;
          break;
        end
        m = m << 1;
        e = e - 1;
        n = n + 1;
      end
    end
    if (zero) begin
      r.sum = 0;
    end else if (e >= (1 << ew) - 1) begin
      r.ovf = 1'b1;
      r.sum = (ls << (w - 1)) | (((1 << ew) - 2) << mw) | ((1 << mw) - 1);
    end else begin
      r.sum = (ls << (w - 1)) | (e << mw) | (m & ((1 << mw) - 1));
    end
    r.lat = d + n + 3;
    r.acc = 0;
    return r;
  endfunction

  function automatic int rand_op(int ew, int mw);
    int e;
    e = $urandom_range(0, (1 << ew) - 2);
    return (int'($urandom_range(0, 1)) << (ew + mw)) | (e << mw) |
           int'($urandom_range(0, (1 << mw) - 1));
  endfunction

  // Result monitors: pop and compare on each rising edge of valid.
  always @(negedge clk) begin
    exp_t e;
    if (valid0 && !v0_prev) begin
      if (q0.size() == 0) begin
        check("dut0 unexpected valid", 32'd1, 32'd0);
      end else begin
        e = q0.pop_front();
        check("dut0 sum", 32'(sum0), e.sum);
        check("dut0 ovf", 32'(ovf0), 32'(e.ovf));
        check("dut0 unf", 32'(unf0), 32'(e.unf));
        check("dut0 latency", cyc - e.acc, e.lat);
      end
      got0++;
    end
    v0_prev = valid0;
  end

  always @(negedge clk) begin
    exp_t e;
    if (valid1 && !v1_prev) begin
      if (q1.size() == 0) begin
        check("dut1 unexpected valid", 32'd1, 32'd0);
      end else begin
        e = q1.pop_front();
        check("dut1 sum", 32'(sum1), e.sum);
        check("dut1 ovf", 32'(ovf1), 32'(e.ovf));
        check("dut1 unf", 32'(unf1), 32'(e.unf));
        check("dut1 latency", cyc - e.acc, e.lat);
      end
      got1++;
    end
    v1_prev = valid1;
  end

  task automatic wait0(input int n);
    for (int i = 0; i < 400 && got0 < n; i++) @(negedge clk);
    if (got0 < n) check("dut0 result timeout", 32'(got0), 32'(n));
  endtask

  task automatic wait1(input int n);
    for (int i = 0; i < 400 && got1 < n; i++) @(negedge clk);
    if (got1 < n) check("dut1 result timeout", 32'(got1), 32'(n));
  endtask

  task automatic issue0(input logic [7:0] av, input logic [7:0] bv, input bit s,
                        input int esum, input bit eovf, input bit eunf, input int elat);
    exp_t e;
    int   target;
    target = got0 + 1;
    @(negedge clk);
    a0 = av; b0 = bv; sub0 = s; start0 = 1'b1;
    e.sum = esum; e.ovf = eovf; e.unf = eunf; e.lat = elat; e.acc = cyc + 1;
    q0.push_back(e);
    @(negedge clk);
    start0 = 1'b0;
    wait0(target);
  endtask

  task automatic issue1(input int av, input int bv, input bit s);
    exp_t e;
    int   target;
    target = got1 + 1;
    @(negedge clk);
    check("dut1 idle before start", 32'(busy1), 32'd0);
    a1 = W1'(av); b1 = W1'(bv); sub1 = s; start1 = 1'b1;
    e = model(4, 7, av, bv, s);
    e.acc = cyc + 1;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    wait1(target);
  endtask

  initial begin
    exp_t e;
    exp_t chain[$];
    int   av, bv, n_before;
    bit   s;

    reset = 1'b1;
    start0 = 1'b0; sub0 = 1'b0; a0 = '0; b0 = '0;
    start1 = 1'b0; sub1 = 1'b0; a1 = '0; b1 = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("reset sum", 32'(sum0), 32'd0);
    check("reset busy", 32'(busy0), 32'd0);
    check("reset valid", 32'(valid0), 32'd0);
    check("reset ovf", 32'(ovf0), 32'd0);
    check("reset unf", 32'(unf0), 32'd0);

    // Directed cases on the default 3/4 format.
    issue0(8'h30, 8'h30, 1'b0, 32'h40, 1'b0, 1'b0, 3);
    issue0(8'h38, 8'h20, 1'b1, 32'h30, 1'b0, 1'b0, 4);
    issue0(8'h38, 8'h30, 1'b1, 32'h20, 1'b0, 1'b0, 4);
    issue0(8'h6F, 8'h6F, 1'b0, 32'h6F, 1'b1, 1'b0, 3);
    issue0(8'h11, 8'h10, 1'b1, 32'h00, 1'b0, 1'b1, 3);
    issue0(8'h30, 8'hB0, 1'b0, 32'h00, 1'b0, 1'b0, 3);
    issue0(8'h6F, 8'hEF, 1'b1, 32'h6F, 1'b1, 1'b0, 3);

    // start during busy with new operands must be ignored.
    n_before = got0;
    @(negedge clk);
    a0 = 8'h30; b0 = 8'h30; sub0 = 1'b0; start0 = 1'b1;
    e.sum = 32'h40; e.ovf = 1'b0; e.unf = 1'b0; e.lat = 3; e.acc = cyc + 1;
    q0.push_back(e);
    @(negedge clk);
    a0 = 8'h00; b0 = 8'h00;
    check("busy after accept", 32'(busy0), 32'd1);
    @(negedge clk);
    start0 = 1'b0;
    wait0(n_before + 1);

    // Reset asserted just after edge 2 aborts the operation with no valid.
    issue0(8'h6F, 8'h6F, 1'b0, 32'h6F, 1'b1, 1'b0, 3);
    n_before = got0;
    @(negedge clk);
    a0 = 8'h38; b0 = 8'h20; sub0 = 1'b1; start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b1;
    @(negedge clk);
    check("abort sum", 32'(sum0), 32'd0);
    check("abort busy", 32'(busy0), 32'd0);
    check("abort valid", 32'(valid0), 32'd0);
    check("abort ovf", 32'(ovf0), 32'd0);
    check("abort unf", 32'(unf0), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("abort produced no valid", 32'(got0), 32'(n_before));
    issue0(8'h38, 8'h20, 1'b1, 32'h30, 1'b0, 1'b0, 4);

    // Back-to-back: start held high, operands changed after each accept.
    for (int k = 0; k < 16; k++) begin
      av = rand_op(3, 4);
      bv = rand_op(3, 4);
      s  = 1'($urandom_range(0, 1));
      e  = model(3, 4, av, bv, s);
      e.acc = int'(s) | (av << 1) | (bv << 9);  // operand stash, replaced below
      chain.push_back(e);
    end
    n_before = got0;
    for (int k = 0; k < chain.size(); k++) begin
      av = (chain[k].acc >> 1) & 8'hFF;
      bv = (chain[k].acc >> 9) & 8'hFF;
      s  = chain[k].acc[0];
      if (k == 0) begin
        @(negedge clk);
        chain[k].acc = cyc + 1;
      end else begin
        chain[k].acc = chain[k-1].acc + chain[k-1].lat + 1;
      end
      a0 = 8'(av); b0 = 8'(bv); sub0 = s; start0 = 1'b1;
      q0.push_back(chain[k]);
      for (int i = 0; i < 60 && cyc < chain[k].acc; i++) @(negedge clk);
    end
    start0 = 1'b0;
    wait0(n_before + chain.size());

    // Randomised sweep on the wider format.
    for (int k = 0; k < 150; k++) begin
      issue1(rand_op(4, 7), rand_op(4, 7), 1'($urandom_range(0, 1)));
    end
    issue1(12'h7FF, 12'h7FF, 1'b0);
    issue1(12'h081, 12'h080, 1'b1);

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
